// File: rtl/conv_row_rd_sequencer.sv
// Row-read sequencer for the conv buffer interface: walks chunks of each output row,
// issues 3-row read requests, rotates row-buffer roles per row and applies top/bottom padding.
module conv_row_rd_sequencer #(
    parameter int ADR_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ADR_W-1:0] cfg_base_adr,
    input  logic [CNT_W-1:0] cfg_chunks,
    input  logic [CNT_W-1:0] cfg_rows,
    input  logic [1:0]       cfg_top_idx,
    input  logic             cfg_pad,
    input  logic             rows_avail,
    input  logic             out_ready,
    output logic [ADR_W-1:0] row1_buf_adr,
    output logic [ADR_W-1:0] row2_buf_adr,
    output logic [ADR_W-1:0] row3_buf_adr,
    output logic             row1_buf_word_select,
    output logic             row2_buf_word_select,
    output logic             row3_buf_word_select,
    output logic [1:0]       row1_buf_idx,
    output logic [1:0]       row2_buf_idx,
    output logic [1:0]       row3_buf_idx,
    output logic [ADR_W-1:0] row1_slab_adr,
    output logic [ADR_W-1:0] row2_slab_adr,
    output logic [ADR_W-1:0] row3_slab_adr,
    output logic [1:0]       row1_slab_idx,
    output logic [1:0]       row2_slab_idx,
    output logic [1:0]       row3_slab_idx,
    output logic             valid_row1_adr,
    output logic             valid_row2_adr,
    output logic             valid_row3_adr,
    output logic [1:0]       last_row1_buf_idx,
    output logic [1:0]       last_row2_buf_idx,
    output logic [1:0]       last_row3_buf_idx,
    output logic [1:0]       last_row1_slab_idx,
    output logic [1:0]       last_row2_slab_idx,
    output logic [1:0]       last_row3_slab_idx,
    output logic             data_valid,
    output logic             row_done,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, WAIT_ROW, STREAM} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] chunk, row, n_chunks, n_rows;
    logic [ADR_W-1:0] base;
    logic             pad;
    logic [1:0]       top;

    // Values presented on the last issue; outputs fall back to these between issues.
    logic [ADR_W-1:0] h_adr, h_slab;
    logic             h_ws;
    logic [1:0]       h_idx1, h_idx2, h_idx3;

    logic             issue, last_chunk, last_row;
    logic [ADR_W-1:0] c_adr, c_slab;
    logic [1:0]       c_idx1, c_idx2, c_idx3;

    function automatic logic [1:0] nxt_idx(input logic [1:0] i);
        return (i == 2'd3) ? 2'd1 : i + 2'd1;
    endfunction

    assign issue      = (state == STREAM) && out_ready;
    assign last_chunk = (chunk == n_chunks - 1'b1);
    assign last_row   = (row == n_rows - 1'b1);

    assign c_adr  = base + ADR_W'(chunk >> 1);
    assign c_slab = (chunk == '0) ? '1 : base + ADR_W'((chunk - 1'b1) >> 1);
    assign c_idx1 = top;
    assign c_idx2 = nxt_idx(top);
    assign c_idx3 = nxt_idx(nxt_idx(top));

    assign row1_buf_adr         = issue ? c_adr : h_adr;
    assign row2_buf_adr         = row1_buf_adr;
    assign row3_buf_adr         = row1_buf_adr;
    assign row1_buf_word_select = issue ? chunk[0] : h_ws;
    assign row2_buf_word_select = row1_buf_word_select;
    assign row3_buf_word_select = row1_buf_word_select;
    assign row1_slab_adr        = issue ? c_slab : h_slab;
    assign row2_slab_adr        = row1_slab_adr;
    assign row3_slab_adr        = row1_slab_adr;
    assign row1_buf_idx         = issue ? c_idx1 : h_idx1;
    assign row2_buf_idx         = issue ? c_idx2 : h_idx2;
    assign row3_buf_idx         = issue ? c_idx3 : h_idx3;
    assign row1_slab_idx        = row1_buf_idx;
    assign row2_slab_idx        = row2_buf_idx;
    assign row3_slab_idx        = row3_buf_idx;

    // Padding suppresses the row above output row 0 and the row below the final row.
    assign valid_row1_adr = issue && !(pad && row == '0);
    assign valid_row2_adr = issue;
    assign valid_row3_adr = issue && !(pad && last_row);
    assign row_done       = issue && last_chunk;
    assign done           = row_done && last_row;
    assign busy           = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = WAIT_ROW;
            WAIT_ROW: if (rows_avail) state_nxt = STREAM;
            STREAM:   if (row_done) state_nxt = last_row ? IDLE : WAIT_ROW;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            chunk      <= '0;
            row        <= '0;
            n_chunks   <= '0;
            n_rows     <= '0;
            base       <= '0;
            pad        <= 1'b0;
            top        <= 2'd0;
            h_adr      <= '0;
            h_slab     <= '1;
            h_ws       <= 1'b0;
            h_idx1     <= 2'd0;
            h_idx2     <= 2'd0;
            h_idx3     <= 2'd0;
            data_valid <= 1'b0;
            last_row1_buf_idx  <= 2'd0;
            last_row2_buf_idx  <= 2'd0;
            last_row3_buf_idx  <= 2'd0;
            last_row1_slab_idx <= 2'd0;
            last_row2_slab_idx <= 2'd0;
            last_row3_slab_idx <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                base     <= cfg_base_adr;
                n_chunks <= (cfg_chunks == '0) ? CNT_W'(1) : cfg_chunks;
                n_rows   <= (cfg_rows == '0) ? CNT_W'(1) : cfg_rows;
                top      <= (cfg_top_idx == 2'd0) ? 2'd1 : cfg_top_idx;
                pad      <= cfg_pad;
                chunk    <= '0;
                row      <= '0;
            end
            if (issue) begin
                h_adr  <= c_adr;
                h_slab <= c_slab;
                h_ws   <= chunk[0];
                h_idx1 <= c_idx1;
                h_idx2 <= c_idx2;
                h_idx3 <= c_idx3;
                if (last_chunk) begin
                    chunk <= '0;
                    row   <= row + 1'b1;
                    top   <= nxt_idx(top);
                end else begin
                    chunk <= chunk + 1'b1;
                end
            end
            data_valid         <= issue;
            last_row1_buf_idx  <= row1_buf_idx;
            last_row2_buf_idx  <= row2_buf_idx;
            last_row3_buf_idx  <= row3_buf_idx;
            last_row1_slab_idx <= row1_slab_idx;
            last_row2_slab_idx <= row2_slab_idx;
            last_row3_slab_idx <= row3_slab_idx;
        end
    end

endmodule

// File: tb/tb_conv_row_rd_sequencer.sv
// Scoreboarded random bench for conv_row_rd_sequencer: a row/chunk model queues expected
// requests; a negedge monitor compares each issued request and the idle/hold behaviour.
module tb_conv_row_rd_sequencer;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [15:0] cfg_base_adr = '0, cfg_chunks = '0, cfg_rows = '0;
    logic [1:0]  cfg_top_idx = '0;
    logic        cfg_pad = 1'b0, rows_avail = 1'b0, out_ready = 1'b0;
    logic [15:0] row1_buf_adr, row2_buf_adr, row3_buf_adr;
    logic        row1_buf_word_select, row2_buf_word_select, row3_buf_word_select;
    logic [1:0]  row1_buf_idx, row2_buf_idx, row3_buf_idx;
    logic [15:0] row1_slab_adr, row2_slab_adr, row3_slab_adr;
    logic [1:0]  row1_slab_idx, row2_slab_idx, row3_slab_idx;
    logic        valid_row1_adr, valid_row2_adr, valid_row3_adr;
    logic [1:0]  last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx;
    logic [1:0]  last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx;
    logic        data_valid, row_done, done, busy;

    conv_row_rd_sequencer #(.ADR_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_base_adr(cfg_base_adr),
        .cfg_chunks(cfg_chunks), .cfg_rows(cfg_rows), .cfg_top_idx(cfg_top_idx),
        .cfg_pad(cfg_pad), .rows_avail(rows_avail), .out_ready(out_ready),
        .row1_buf_adr(row1_buf_adr), .row2_buf_adr(row2_buf_adr), .row3_buf_adr(row3_buf_adr),
        .row1_buf_word_select(row1_buf_word_select), .row2_buf_word_select(row2_buf_word_select),
        .row3_buf_word_select(row3_buf_word_select),
        .row1_buf_idx(row1_buf_idx), .row2_buf_idx(row2_buf_idx), .row3_buf_idx(row3_buf_idx),
        .row1_slab_adr(row1_slab_adr), .row2_slab_adr(row2_slab_adr), .row3_slab_adr(row3_slab_adr),
        .row1_slab_idx(row1_slab_idx), .row2_slab_idx(row2_slab_idx), .row3_slab_idx(row3_slab_idx),
        .valid_row1_adr(valid_row1_adr), .valid_row2_adr(valid_row2_adr), .valid_row3_adr(valid_row3_adr),
        .last_row1_buf_idx(last_row1_buf_idx), .last_row2_buf_idx(last_row2_buf_idx),
        .last_row3_buf_idx(last_row3_buf_idx), .last_row1_slab_idx(last_row1_slab_idx),
        .last_row2_slab_idx(last_row2_slab_idx), .last_row3_slab_idx(last_row3_slab_idx),
        .data_valid(data_valid), .row_done(row_done), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] adr;
        logic        ws;
        logic [1:0]  i1, i2, i3;
        logic [15:0] slab;
        logic        v1, v3, rd, dn, cons;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected request stream straight from the row/chunk rules.
    task automatic push_model(input logic [15:0] base, input int chunks, input int rows,
                              input int top, input bit pad);
        int   ch = (chunks == 0) ? 1 : chunks;
        int   rw = (rows == 0) ? 1 : rows;
        int   t  = (top == 0) ? 1 : top;
        exp_t e;
        for (int r = 0; r < rw; r++) begin
            for (int k = 0; k < ch; k++) begin
                e      = '0;
                e.adr  = base + 16'(k / 2);
                e.ws   = (k % 2) == 1;
                e.i1   = 2'(t);
                e.i2   = 2'(t % 3 + 1);
                e.i3   = 2'((t % 3 + 1) % 3 + 1);
                e.slab = (k == 0) ? 16'hffff : base + 16'((k - 1) / 2);
                e.v1   = !(pad && r == 0);
                e.v3   = !(pad && r == rw - 1);
                e.rd   = (k == ch - 1);
                e.dn   = e.rd && (r == rw - 1);
                e.cons = 1'b1;
                q.push_back(e);
            end
            t = t % 3 + 1;
        end
    endtask

    exp_t        held, act, e_pop;
    logic        prev_issue;
    logic [11:0] prev_idx;

    always @(negedge clk) begin
        if (reset) begin
            prev_issue = 1'b0;
            prev_idx   = '0;
            held       = '0;
            held.slab  = 16'hffff;
            held.cons  = 1'b1;
        end else begin
            act      = '0;
            act.adr  = row1_buf_adr;
            act.ws   = row1_buf_word_select;
            act.i1   = row1_buf_idx;
            act.i2   = row2_buf_idx;
            act.i3   = row3_buf_idx;
            act.slab = row1_slab_adr;
            act.v1   = valid_row1_adr;
            act.v3   = valid_row3_adr;
            act.rd   = row_done;
            act.dn   = done;
            act.cons = (row2_buf_adr == row1_buf_adr) && (row3_buf_adr == row1_buf_adr) &&
                       (row2_buf_word_select == row1_buf_word_select) &&
                       (row3_buf_word_select == row1_buf_word_select) &&
                       (row2_slab_adr == row1_slab_adr) && (row3_slab_adr == row1_slab_adr) &&
                       (row1_slab_idx == row1_buf_idx) && (row2_slab_idx == row2_buf_idx) &&
                       (row3_slab_idx == row3_buf_idx);
            chk("data_valid", data_valid, prev_issue);
            chk("last_idx", {last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx,
                             last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx}, prev_idx);
            if (valid_row2_adr) begin
                if (q.size() == 0) chk("unexpected_issue", 1, 0);
                else begin
                    e_pop = q.pop_front();
                    chk("issue", act, e_pop);
                    held = e_pop;
                end
            end else begin
                chk("idle_flags", {valid_row1_adr, valid_row3_adr, row_done, done}, 0);
                chk("hold", {act.adr, act.ws, act.i1, act.i2, act.i3, act.slab, act.cons},
                            {held.adr, held.ws, held.i1, held.i2, held.i3, held.slab, held.cons});
            end
            prev_issue = valid_row2_adr;
            prev_idx   = {row1_buf_idx, row2_buf_idx, row3_buf_idx,
                          row1_slab_idx, row2_slab_idx, row3_slab_idx};
        end
    end

    task automatic run_job(input logic [15:0] base, input int chunks, input int rows,
                           input int top, input bit pad, input int p_rdy, input int p_av,
                           input bit poke);
        @(posedge clk); #1;
        cfg_base_adr = base;
        cfg_chunks   = 16'(chunks);
        cfg_rows     = 16'(rows);
        cfg_top_idx  = 2'(top);
        cfg_pad      = pad;
        start        = 1'b1;
        out_ready    = ($urandom_range(0, 99) < p_rdy);
        rows_avail   = ($urandom_range(0, 99) < p_av);
        push_model(base, chunks, rows, top, pad);
        for (int cyc = 0; ; cyc++) begin
            @(posedge clk); #1;
            start      = 1'b0;
            out_ready  = ($urandom_range(0, 99) < p_rdy);
            rows_avail = ($urandom_range(0, 99) < p_av);
            if (poke && busy && $urandom_range(0, 3) == 0) begin
                start        = 1'b1;
                cfg_base_adr = 16'($urandom);
                cfg_chunks   = 16'($urandom_range(1, 9));
                cfg_rows     = 16'($urandom_range(1, 5));
                cfg_top_idx  = 2'($urandom);
                cfg_pad      = 1'($urandom);
            end
            if (!busy && q.size() == 0) break;
            if (cyc > 3000) begin
                chk("job_timeout", 1, 0);
                q.delete();
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_state", {busy, valid_row2_adr, data_valid, row1_buf_idx, row1_buf_adr},
                           {1'b0, 1'b0, 1'b0, 2'd0, 16'h0000});
        chk("reset_slab", row1_slab_adr, 16'hffff);

        run_job(16'h0010, 4, 1, 1, 0, 100, 100, 0);
        run_job(16'h0200, 2, 3, 2, 0, 100, 100, 0);
        run_job(16'h0040, 3, 3, 1, 1, 100, 100, 0);
        run_job(16'h0080, 4, 2, 3, 0, 50, 100, 1);
        run_job(16'hfffe, 6, 1, 0, 1, 70, 70, 0);
        run_job(16'h0005, 0, 0, 2, 0, 100, 100, 0);

        // Loader handshake: hold rows_avail low after row 0, then release.
        @(posedge clk); #1;
        cfg_base_adr = 16'h0300; cfg_chunks = 16'd2; cfg_rows = 16'd2;
        cfg_top_idx = 2'd1; cfg_pad = 1'b0;
        start = 1'b1; out_ready = 1'b1; rows_avail = 1'b1;
        push_model(16'h0300, 2, 2, 1, 0);
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (row_done) break;
        end
        chk("hs_row_done", row_done, 1);
        #1 rows_avail = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hs_stall", {valid_row2_adr, busy}, 2'b01);
        end
        #1 rows_avail = 1'b1;
        @(negedge clk);
        chk("hs_resume", valid_row2_adr, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy && q.size() == 0) break;
        end
        chk("hs_finish", {busy, q.size() == 0}, 2'b01);

        // Reset in the middle of row 1 (chunk 2).
        @(posedge clk); #1;
        cfg_base_adr = 16'h0400; cfg_chunks = 16'd4; cfg_rows = 16'd3;
        cfg_top_idx = 2'd1; cfg_pad = 1'b0;
        start = 1'b1; out_ready = 1'b1; rows_avail = 1'b1;
        push_model(16'h0400, 4, 3, 1, 0);
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid_row2_adr) begin
                if (n == 6) break;
                n++;
            end
        end
        chk("rst_reached", n, 6);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_state", {busy, valid_row1_adr, valid_row2_adr, valid_row3_adr, data_valid,
                          done, row_done, row1_buf_idx, row3_buf_idx}, 0);
        @(posedge clk); #1 reset = 1'b0;
        q.delete();

        for (int j = 0; j < 12; j++)
            run_job(16'($urandom), $urandom_range(0, 6), $urandom_range(0, 4),
                    $urandom_range(0, 3), 1'($urandom), $urandom_range(30, 100),
                    $urandom_range(30, 100), 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
